// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file and the hazard unit:
// default geometry and the pending-write counter command encoding.
package regfile_pkg;

    localparam int unsigned XLEN_DEF   = 64;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned NREAD_DEF  = 2;
    localparam int unsigned PEND_W_DEF = 2;

    // Command applied to one pending-write counter in a cycle.
    typedef enum logic [1:0] {
        PEND_NONE = 2'b00,
        PEND_INC  = 2'b01,
        PEND_DEC  = 2'b10,
        PEND_HOLD = 2'b11
    } pend_cmd_e;

    // Encode a reserve/writeback pair into a counter command; a reserve and
    // a writeback in the same cycle cancel out.
    function automatic pend_cmd_e pend_cmd_f(input logic inc, input logic dec);
        pend_cmd_e cmd;
        case ({inc, dec})
            2'b10:   cmd = PEND_INC;
            2'b01:   cmd = PEND_DEC;
            2'b11:   cmd = PEND_HOLD;
            default: cmd = PEND_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Per-register pending-write counter. Saturation is prevented upstream by
// the reserve handshake; a decrement at zero leaves the count alone and
// raises a one-cycle underflow pulse.
module pend_counter
    import regfile_pkg::*;
#(
    parameter int unsigned PEND_W = PEND_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] count_o,
    output logic              zero_o,
    output logic              max_o,
    output logic              underflow_o
);

    localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};

    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;
    logic              underflow_s;
    pend_cmd_e         cmd_s;

    // Next-count and underflow detection from the decoded command.
    always_comb begin
        cmd_s       = pend_cmd_f(inc_i, dec_i);
        count_d     = count_q;
        underflow_s = 1'b0;
        case (cmd_s)
            PEND_INC: begin
                if (count_q != CNT_MAX) begin
                    count_d = count_q + PEND_W'(1);
                end else begin
                    count_d = count_q;
                end
            end
            PEND_DEC: begin
                if (count_q != CNT_ZERO) begin
                    count_d = count_q - PEND_W'(1);
                end else begin
                    underflow_s = 1'b1;
                end
            end
            PEND_NONE, PEND_HOLD: begin
                count_d = count_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign zero_o      = (count_q == CNT_ZERO);
    assign max_o       = (count_q == CNT_MAX);
    assign underflow_o = underflow_s;

endmodule

// File: rtl/regfile_scoreboard.sv
// Pipelined-core integer register file with write-to-read bypass and a
// per-register pending-write scoreboard used by decode for RAW stalls.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NREAD  = NREAD_DEF,
    parameter  int unsigned PEND_W = PEND_W_DEF,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  rsv_valid,
    input  logic [AW-1:0]         rsv_addr,
    output logic                  rsv_ready,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  any_pending,
    output logic                  err_underflow
);

    localparam logic [AW-1:0]     ADDR_ZERO = {AW{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ZERO  = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ONE   = PEND_W'(1);

    logic [XLEN-1:0]   regs_q   [NREGS];
    logic [PEND_W-1:0] cnt_s    [NREGS];
    logic [NREGS-1:0]  zero_s;
    logic [NREGS-1:0]  max_s;
    logic [NREGS-1:0]  uf_s;
    logic              rsv_acc_s;
    logic              rsv_ready_s;
    logic              err_underflow_q;

    logic [AW-1:0]     rd_addr_s [NREAD];
    logic [XLEN-1:0]   rd_data_s [NREAD];
    logic              rd_busy_s [NREAD];

    // x0 has no counter: it is never pending and never saturates.
    assign cnt_s[0]  = CNT_ZERO;
    assign zero_s[0] = 1'b1;
    assign max_s[0]  = 1'b0;
    assign uf_s[0]   = 1'b0;

    // No credit is taken from a same-cycle writeback: only the current
    // count decides whether another reservation fits.
    assign rsv_ready_s = reset_n & ((rsv_addr == ADDR_ZERO) | ~max_s[rsv_addr]);
    assign rsv_acc_s   = rsv_valid & rsv_ready_s;

    genvar r;
    generate
        for (r = 1; r < NREGS; r++) begin : g_pend
            pend_counter #(
                .PEND_W(PEND_W)
            ) u_pend (
                .clock      (clock),
                .reset_n    (reset_n),
                .inc_i      (rsv_acc_s && (rsv_addr == AW'(r))),
                .dec_i      (wb_valid && (wb_addr == AW'(r))),
                .count_o    (cnt_s[r]),
                .zero_o     (zero_s[r]),
                .max_o      (max_s[r]),
                .underflow_o(uf_s[r])
            );
        end
    endgenerate

    // Architectural register storage; x0 stays zero because it is never written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_valid && (wb_addr == AW'(i))) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_underflow_q <= 1'b0;
        end else if (|uf_s) begin
            err_underflow_q <= 1'b1;
        end else begin
            err_underflow_q <= err_underflow_q;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NREAD; p++) begin : g_rd
            assign rd_addr_s[p] = rd_addr[p*AW +: AW];

            // Read mux with bypass; a last outstanding write landing this
            // cycle is forwarded, so the source is not reported busy.
            always_comb begin
                rd_data_s[p] = {XLEN{1'b0}};
                rd_busy_s[p] = 1'b0;
                if (!reset_n) begin
                    rd_data_s[p] = {XLEN{1'b0}};
                    rd_busy_s[p] = 1'b0;
                end else if (rd_addr_s[p] == ADDR_ZERO) begin
                    rd_data_s[p] = {XLEN{1'b0}};
                    rd_busy_s[p] = 1'b0;
                end else begin
                    if (wb_valid && (wb_addr == rd_addr_s[p])) begin
                        rd_data_s[p] = wb_data;
                        rd_busy_s[p] = (cnt_s[rd_addr_s[p]] != CNT_ZERO) &&
                                       (cnt_s[rd_addr_s[p]] != CNT_ONE);
                    end else begin
                        rd_data_s[p] = regs_q[rd_addr_s[p]];
                        rd_busy_s[p] = (cnt_s[rd_addr_s[p]] != CNT_ZERO);
                    end
                end
            end

            assign rd_data[p*XLEN +: XLEN] = rd_data_s[p];
            assign rd_busy[p]              = rd_busy_s[p];
        end
    endgenerate

    assign rsv_ready     = rsv_ready_s;
    assign any_pending   = reset_n & ~(&zero_s);
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard at default parameters.
module tb_regfile_scoreboard;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int PEND_W = 2;
    localparam int AW     = 5;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  rsv_valid;
    logic [AW-1:0]         rsv_addr;
    logic                  rsv_ready;
    logic                  wb_valid;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  any_pending;
    logic                  err_underflow;

    int vectors     = 0;
    int miscompares = 0;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .PEND_W(PEND_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .any_pending(any_pending), .err_underflow(err_underflow)
    );

    always #5 clock = ~clock;

    wire [XLEN-1:0] p0 = rd_data[XLEN-1:0];
    wire [XLEN-1:0] p1 = rd_data[2*XLEN-1:XLEN];

    task automatic idle();
        rsv_valid = 1'b0; rsv_addr = 5'd0;
        wb_valid  = 1'b0; wb_addr  = 5'd0; wb_data = 64'd0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_rd(5'd5, 5'd5);
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 64'hDEAD;
        #2;
        vectors++; if (p0 !== 64'd0) begin miscompares++; $display("FAIL in_reset_rd_data: got %h want 0", p0); end
        vectors++; if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL in_reset_rd_busy: got %b want 00", rd_busy); end
        vectors++; if (rsv_ready !== 1'b0) begin miscompares++; $display("FAIL in_reset_rsv_ready: got %b want 0", rsv_ready); end
        vectors++; if (any_pending !== 1'b0) begin miscompares++; $display("FAIL in_reset_any_pending: got %b want 0", any_pending); end
        step(); step();
        idle();
        @(negedge clock) reset_n = 1'b1;
        step();
        // reserve x5, write it, reserve x6 (left outstanding)
        rsv_valid = 1'b1; rsv_addr = 5'd5; step();
        idle(); wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 64'hDEAD; step();
        idle(); rsv_valid = 1'b1; rsv_addr = 5'd6; step();
        idle(); #1;
        vectors++; if (p0 !== 64'hDEAD) begin miscompares++; $display("FAIL stored_x5: got %h want dead", p0); end
        vectors++; if (any_pending !== 1'b1) begin miscompares++; $display("FAIL pending_x6: got %b want 1", any_pending); end
        #1 reset_n = 1'b0;
        #1;
        vectors++; if (p0 !== 64'd0) begin miscompares++; $display("FAIL midcycle_reset_x5: got %h want 0", p0); end
        vectors++; if (any_pending !== 1'b0) begin miscompares++; $display("FAIL midcycle_reset_pending: got %b want 0", any_pending); end
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL midcycle_reset_err: got %b want 0", err_underflow); end
        #1 reset_n = 1'b1;
        step();
        set_rd(5'd5, 5'd6); rsv_addr = 5'd6; #1;
        vectors++; if (p0 !== 64'd0) begin miscompares++; $display("FAIL post_reset_x5: got %h want 0", p0); end
        vectors++; if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL post_reset_busy: got %b want 00", rd_busy); end
        vectors++; if (rsv_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_rsv_ready: got %b want 1", rsv_ready); end
    endtask

    task automatic test_x0();
        idle(); set_rd(5'd0, 5'd0);
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 64'hFFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        #1;
        vectors++; if (p0 !== 64'd0 || p1 !== 64'd0) begin miscompares++; $display("FAIL x0_read: got %h %h want 0 0", p0, p1); end
        vectors++; if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL x0_busy: got %b want 00", rd_busy); end
        vectors++; if (rsv_ready !== 1'b1) begin miscompares++; $display("FAIL x0_rsv_ready: got %b want 1", rsv_ready); end
        step();
        idle(); #1;
        vectors++; if (p0 !== 64'd0) begin miscompares++; $display("FAIL x0_after_write: got %h want 0", p0); end
        vectors++; if (any_pending !== 1'b0) begin miscompares++; $display("FAIL x0_pending: got %b want 0", any_pending); end
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL x0_err: got %b want 0", err_underflow); end
    endtask

    task automatic test_bypass();
        idle(); set_rd(5'd3, 5'd3);
        rsv_valid = 1'b1; rsv_addr = 5'd3; #1;
        vectors++; if (rsv_ready !== 1'b1) begin miscompares++; $display("FAIL byp_rsv_ready: got %b want 1", rsv_ready); end
        step();
        idle(); #1;
        vectors++; if (rd_busy !== 2'b11) begin miscompares++; $display("FAIL byp_busy_before: got %b want 11", rd_busy); end
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234; #1;
        vectors++; if (p0 !== 64'h1234 || p1 !== 64'h1234) begin miscompares++; $display("FAIL byp_data: got %h %h want 1234 1234", p0, p1); end
        vectors++; if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL byp_busy: got %b want 00", rd_busy); end
        step();
        idle(); #1;
        vectors++; if (p0 !== 64'h1234) begin miscompares++; $display("FAIL byp_stored: got %h want 1234", p0); end
        vectors++; if (rd_busy !== 2'b00 || any_pending !== 1'b0) begin miscompares++; $display("FAIL byp_cnt_zero: got busy %b pending %b want 00 0", rd_busy, any_pending); end
    endtask

    task automatic test_multi();
        idle(); set_rd(5'd7, 5'd0);
        for (int k = 0; k < 3; k++) begin
            rsv_valid = 1'b1; rsv_addr = 5'd7; #1;
            vectors++; if (rsv_ready !== 1'b1) begin miscompares++; $display("FAIL multi_rsv_%0d: got %b want 1", k, rsv_ready); end
            step();
        end
        #1;
        vectors++; if (rsv_ready !== 1'b0) begin miscompares++; $display("FAIL multi_rsv_full: got %b want 0", rsv_ready); end
        step();
        rsv_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 64'h11; #1;
        vectors++; if (rd_busy[0] !== 1'b1 || p0 !== 64'h11) begin miscompares++; $display("FAIL multi_wb1: got busy %b data %h want 1 11", rd_busy[0], p0); end
        step();
        idle(); rsv_addr = 5'd7; #1;
        vectors++; if (rd_busy[0] !== 1'b1) begin miscompares++; $display("FAIL multi_busy_cnt2: got %b want 1", rd_busy[0]); end
        vectors++; if (rsv_ready !== 1'b1) begin miscompares++; $display("FAIL multi_rsv_ready_back: got %b want 1", rsv_ready); end
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 64'h22; #1;
        vectors++; if (rd_busy[0] !== 1'b1) begin miscompares++; $display("FAIL multi_wb2_busy: got %b want 1", rd_busy[0]); end
        step();
        wb_data = 64'h33; #1;
        vectors++; if (rd_busy[0] !== 1'b0 || p0 !== 64'h33) begin miscompares++; $display("FAIL multi_wb3: got busy %b data %h want 0 33", rd_busy[0], p0); end
        step();
        idle(); #1;
        vectors++; if (any_pending !== 1'b0 || err_underflow !== 1'b0) begin miscompares++; $display("FAIL multi_drained: got pending %b err %b want 0 0", any_pending, err_underflow); end
    endtask

    task automatic test_simultaneous();
        idle(); set_rd(5'd9, 5'd10);
        rsv_valid = 1'b1; rsv_addr = 5'd9; step();
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 64'h55; #1;
        vectors++; if (rsv_ready !== 1'b1) begin miscompares++; $display("FAIL simul_rsv_ready: got %b want 1", rsv_ready); end
        vectors++; if (p0 !== 64'h55 || rd_busy[0] !== 1'b0) begin miscompares++; $display("FAIL simul_same_cycle: got data %h busy %b want 55 0", p0, rd_busy[0]); end
        step();
        idle(); #1;
        vectors++; if (rd_busy[0] !== 1'b1 || p0 !== 64'h55) begin miscompares++; $display("FAIL simul_next: got busy %b data %h want 1 55", rd_busy[0], p0); end
        rsv_valid = 1'b1; rsv_addr = 5'd10;
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 64'h66; #1;
        vectors++; if (p1 !== 64'h66 || rd_busy[1] !== 1'b0) begin miscompares++; $display("FAIL simul_x10_same: got data %h busy %b want 66 0", p1, rd_busy[1]); end
        step();
        idle(); #1;
        vectors++; if (rd_busy[1] !== 1'b0 || err_underflow !== 1'b0) begin miscompares++; $display("FAIL simul_x10_next: got busy %b err %b want 0 0", rd_busy[1], err_underflow); end
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 64'h56; step();
        idle(); #1;
        vectors++; if (any_pending !== 1'b0 || p0 !== 64'h56) begin miscompares++; $display("FAIL simul_drain: got pending %b data %h want 0 56", any_pending, p0); end
    endtask

    task automatic test_underflow();
        idle(); set_rd(5'd4, 5'd0);
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 64'h77; #1;
        vectors++; if (p0 !== 64'h77 || err_underflow !== 1'b0) begin miscompares++; $display("FAIL uf_same_cycle: got data %h err %b want 77 0", p0, err_underflow); end
        step();
        idle(); #1;
        vectors++; if (err_underflow !== 1'b1 || p0 !== 64'h77) begin miscompares++; $display("FAIL uf_next: got err %b data %h want 1 77", err_underflow, p0); end
        vectors++; if (any_pending !== 1'b0) begin miscompares++; $display("FAIL uf_pending: got %b want 0", any_pending); end
        step(); step(); step();
        vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL uf_reset_clear: got %b want 0", err_underflow); end
        #1 reset_n = 1'b1;
        step();
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL uf_after_reset: got %b want 0", err_underflow); end
    endtask

    initial begin
        idle();
        rd_addr = '0;
        reset_n = 1'b0;
        test_reset();
        test_x0();
        test_bypass();
        test_multi();
        test_simultaneous();
        test_underflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
